turn_sequencer: RTL and testbench
=================================

TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000000, cycles allowed per turn (used only with TURN_TIMEOUT_EN).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  current player's move committed; advance turn.
REQ-006 new_game  input  1  synchronous restart at first_player.
REQ-007 first_player  input  PW  index of starting player for new_game; PW = max(1, clog2(NUM_PLAYERS)).
REQ-008 active_mask  input  NUM_PLAYERS  bit i high = player i still in game.
REQ-009 q  output  NUM_PLAYERS  one-hot current player, registered.
REQ-010 player_idx  output  PW  binary index of current player, registered, always consistent with q.
REQ-011 turn_count  output  8  completed turns since reset/new_game, wraps 255->0.
REQ-012 timed_out  output  1  one-cycle pulse on timeout-forced advance.

Function
REQ-013 Next player SHALL be the nearest index above current, cyclic, with active_mask bit set; if none other than current, current is retained.
REQ-014 enable sampled high SHALL update q/player_idx on the same edge (1-cycle latency) and increment turn_count.
REQ-015 enable while the next player equals current SHALL leave q unchanged but still increment turn_count.
REQ-016 If current player's active_mask bit is low and enable is low, the block SHALL force-advance on the next edge without incrementing turn_count.
REQ-017 If active_mask is all zero, q, player_idx and turn_count SHALL hold; enable ignored.
REQ-018 new_game SHALL load q to one-hot(first_player), clear turn_count, clear timer; priority new_game > enable > forced skip > timeout.
REQ-019 first_player >= NUM_PLAYERS on new_game SHALL load player 0.
REQ-020 q SHALL never be zero nor multi-hot outside reset.

Reset
REQ-021 reset SHALL asynchronously force q = one-hot player 0 (value 1), player_idx = 0, turn_count = 0, timed_out = 0, timer = 0.
REQ-022 reset asserted mid-turn or mid-timeout SHALL abort with no timed_out pulse; first advance possible on the first edge after deassertion.

Configuration
REQ-023 Macro TURN_TIMEOUT_EN defined: per-turn cycle counter runs, cleared on every advance/new_game; reaching TIMEOUT_CYCLES-1 without enable SHALL advance per REQ-013, pulse timed_out, increment turn_count.
REQ-024 Macro undefined: no counter synthesised, timed_out tied 0, TIMEOUT_CYCLES ignored.
REQ-025 With macro, enable on the timeout cycle SHALL win; timed_out stays 0.

Structure
REQ-026 Package turn_pkg SHALL hold MAX_PLAYERS=8, TURN_CNT_W=8, and the PW width function.
REQ-027 Sub-module next_player_finder SHALL be the combinational rotate-priority encoder (current one-hot, active_mask -> next one-hot, index).

Verification
REQ-028 NUM_PLAYERS=2, mask 11, enable x3 -> q 01,10,01,10; turn_count 3.
REQ-029 NUM_PLAYERS=4, mask 1011, current player 1, enable -> q 1000 (player 3), skipping player 2.
REQ-030 NUM_PLAYERS=4, current player 2, mask drops bit 2 -> next edge q 1000, turn_count unchanged.
REQ-031 new_game with first_player=2 and enable same cycle -> q 0100, turn_count 0.
REQ-032 TURN_TIMEOUT_EN, TIMEOUT_CYCLES=10, no enable -> advance and timed_out pulse at cycle 10; enable at cycle 9 of next turn -> no pulse.
REQ-033 reset asserted between clock edges mid-timeout -> q 0001 immediately, timed_out 0.

Source files
------------

// File: rtl/turn_pkg.sv
// Shared constants and width helper for the turn sequencer.
package turn_pkg;
  localparam int MAX_PLAYERS = 8;
  localparam int TURN_CNT_W  = 8;

  // Player index width, never narrower than one bit.
  function automatic int pw(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/next_player_finder.sv
// Rotate-priority encoder: nearest active player above the current one, cyclic.
module next_player_finder
  import turn_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = pw(N)
) (
  input  logic [N-1:0]  cur,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  nxt,
  output logic [PW-1:0] nxt_idx
);

  always_comb begin
    int cur_idx;
    int j;
    cur_idx = 0;
    j       = 0;
    for (int i = 0; i < N; i++)
      if (cur[i]) cur_idx = i;
    nxt     = cur;
    nxt_idx = PW'(cur_idx);
    // Walk farthest to nearest so the closest active candidate is the last write.
    for (int k = N - 1; k >= 1; k--) begin
      j = cur_idx + k;
      if (j >= N) j = j - N;
      if (mask[j]) begin
        nxt     = '0;
        nxt[j]  = 1'b1;
        nxt_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Round-robin turn sequencer over active players.
// Optional per-turn timeout enabled by defining TURN_TIMEOUT_EN.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          new_game,
  input  logic [pw(NUM_PLAYERS)-1:0]    first_player,
  input  logic [NUM_PLAYERS-1:0]        active_mask,
  output logic [NUM_PLAYERS-1:0]        q,
  output logic [pw(NUM_PLAYERS)-1:0]    player_idx,
  output logic [TURN_CNT_W-1:0]         turn_count,
  output logic                          timed_out
);

  localparam int PW = pw(NUM_PLAYERS);

  logic [NUM_PLAYERS-1:0] nxt, start_q;
  logic [PW-1:0]          nxt_idx, start_idx;
  logic                   any_active, cur_off, expired, advance;

  next_player_finder #(.N(NUM_PLAYERS), .PW(PW)) u_finder (
    .cur     (q),
    .mask    (active_mask),
    .nxt     (nxt),
    .nxt_idx (nxt_idx)
  );

  always_comb begin
    start_idx = (int'(first_player) < NUM_PLAYERS) ? first_player : '0;
    start_q   = '0;
    start_q[start_idx] = 1'b1;
  end

  assign any_active = |active_mask;
  assign cur_off    = ~|(q & active_mask);
  assign advance    = any_active & (enable | cur_off | expired);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q          <= NUM_PLAYERS'(1);
      player_idx <= '0;
      turn_count <= '0;
    end else if (new_game) begin
      q          <= start_q;
      player_idx <= start_idx;
      turn_count <= '0;
    end else if (advance) begin
      q          <= nxt;
      player_idx <= nxt_idx;
      // A skip of a dropped player is not a completed turn.
      if (enable || !cur_off) turn_count <= turn_count + 1'b1;
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer;

  assign expired = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      timed_out <= 1'b0;
    end else begin
      timed_out <= !new_game && any_active && !enable && !cur_off && expired;
      if (new_game || advance) timer <= '0;
      else if (any_active)     timer <= timer + 1'b1;
    end
  end
`else
  assign expired   = 1'b0;
  // Constant zero; the parameter only matters when the timer is built.
  assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed scoreboard bench for turn_sequencer (2, 3 and 4 player instances).
module tb_turn_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       en4 = 0, ng4 = 0; logic [1:0] fp4 = 0; logic [3:0] m4 = 4'b1111;
  logic       en2 = 0, ng2 = 0; logic [0:0] fp2 = 0; logic [1:0] m2 = 2'b11;
  logic       en3 = 0, ng3 = 0; logic [1:0] fp3 = 0; logic [2:0] m3 = 3'b111;
  logic [3:0] q4; logic [1:0] i4; logic [7:0] c4; logic t4;
  logic [1:0] q2; logic [0:0] i2; logic [7:0] c2; logic t2;
  logic [2:0] q3; logic [1:0] i3; logic [7:0] c3; logic t3;

  turn_sequencer #(.NUM_PLAYERS(4), .TIMEOUT_CYCLES(10)) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .new_game(ng4), .first_player(fp4),
    .active_mask(m4), .q(q4), .player_idx(i4), .turn_count(c4), .timed_out(t4));
  turn_sequencer #(.NUM_PLAYERS(2), .TIMEOUT_CYCLES(100000)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .new_game(ng2), .first_player(fp2),
    .active_mask(m2), .q(q2), .player_idx(i2), .turn_count(c2), .timed_out(t2));
  turn_sequencer #(.NUM_PLAYERS(3), .TIMEOUT_CYCLES(100000)) dut3 (
    .clk(clk), .reset(reset), .enable(en3), .new_game(ng3), .first_player(fp3),
    .active_mask(m3), .q(q3), .player_idx(i3), .turn_count(c3), .timed_out(t3));

  typedef struct {
    int         dut;
    string      tag;
    logic [7:0] q;
    logic [7:0] idx;
    logic [7:0] cnt;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_out(input int d, input string tag, input int qv, input int iv,
                            input int cv, input bit tv);
    exp_t e;
    e.dut = d; e.tag = tag; e.q = 8'(qv); e.idx = 8'(iv); e.cnt = 8'(cv); e.to = tv;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] gq, gi, gc, gt;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        4:       begin gq = 8'(q4); gi = 8'(i4); gc = c4; gt = 8'(t4); end
        2:       begin gq = 8'(q2); gi = 8'(i2); gc = c2; gt = 8'(t2); end
        default: begin gq = 8'(q3); gi = 8'(i3); gc = c3; gt = 8'(t3); end
      endcase
      cmp({e.tag, ".q"},   gq, e.q);
      cmp({e.tag, ".idx"}, gi, e.idx);
      cmp({e.tag, ".cnt"}, gc, e.cnt);
      cmp({e.tag, ".to"},  gt, 8'(e.to));
    end
  endtask

  // Advance one edge, then compare everything queued for that edge.
  task automatic cyc();
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    #12;
    expect_out(4, "rst4", 1, 0, 0, 0);
    expect_out(2, "rst2", 1, 0, 0, 0);
    expect_out(3, "rst3", 1, 0, 0, 0);
    drain();
    @(posedge clk); #1; reset = 0;

    // 4-player directed walk
    en4 = 1;                       expect_out(4, "adv1", 4'b0010, 1, 1, 0); cyc();
    m4 = 4'b1011;                  expect_out(4, "skip2", 4'b1000, 3, 2, 0); cyc();
                                   expect_out(4, "wrap", 4'b0001, 0, 3, 0); cyc();
    ng4 = 1; fp4 = 2; m4 = 4'b1111; expect_out(4, "ng_en", 4'b0100, 2, 0, 0); cyc();
    ng4 = 0; en4 = 0; m4 = 4'b1011; expect_out(4, "drop", 4'b1000, 3, 0, 0); cyc();
    en4 = 1; m4 = 4'b0000;         expect_out(4, "allzero", 4'b1000, 3, 0, 0); cyc();
    m4 = 4'b1000;                  expect_out(4, "solo", 4'b1000, 3, 1, 0); cyc();
    en4 = 0; m4 = 4'b1111;         expect_out(4, "idle", 4'b1000, 3, 1, 0); cyc();
    en4 = 1; m4 = 4'b0110;         expect_out(4, "en_off", 4'b0010, 1, 2, 0); cyc();
    en4 = 0; m4 = 4'b1111; ng4 = 1; fp4 = 0;
                                   expect_out(4, "ng0", 4'b0001, 0, 0, 0); cyc();
    ng4 = 0;
`ifdef TURN_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin expect_out(4, "to_wait", 4'b0001, 0, 0, 0); cyc(); end
    expect_out(4, "to_fire", 4'b0010, 1, 1, 1); cyc();
    for (int i = 0; i < 8; i++) begin expect_out(4, "to_wait2", 4'b0010, 1, 1, 0); cyc(); end
    en4 = 1;                       expect_out(4, "en_c9", 4'b0100, 2, 2, 0); cyc();
    en4 = 0;
    for (int i = 0; i < 9; i++) begin expect_out(4, "to_wait3", 4'b0100, 2, 2, 0); cyc(); end
    en4 = 1;                       expect_out(4, "en_c10", 4'b1000, 3, 3, 0); cyc();
    en4 = 0;                       expect_out(4, "post", 4'b1000, 3, 3, 0); cyc();
`else
    for (int i = 0; i < 12; i++) begin expect_out(4, "no_to", 4'b0001, 0, 0, 0); cyc(); end
`endif

    // 2-player alternation and counter wrap
    en2 = 1;
    expect_out(2, "p2a", 2'b10, 1, 1, 0); cyc();
    expect_out(2, "p2b", 2'b01, 0, 2, 0); cyc();
    expect_out(2, "p2c", 2'b10, 1, 3, 0); cyc();
    for (int i = 0; i < 252; i++) cyc();
    expect_out(2, "cnt_wrap", 2'b01, 0, 0, 0); cyc();
    en2 = 0;

    // 3-player: out-of-range first_player falls back to 0
    en3 = 1;                       expect_out(3, "p3a", 3'b010, 1, 1, 0); cyc();
    en3 = 0; ng3 = 1; fp3 = 3;     expect_out(3, "fp_oor", 3'b001, 0, 0, 0); cyc();
    en3 = 1; fp3 = 2;              expect_out(3, "fp2", 3'b100, 2, 0, 0); cyc();
    ng3 = 0; m3 = 3'b011;          expect_out(3, "p3wrap", 3'b001, 0, 1, 0); cyc();
    en3 = 0; m3 = 3'b111;

    // Reset dropped between edges in the middle of a turn
    ng4 = 1; fp4 = 0;              expect_out(4, "ng_r", 4'b0001, 0, 0, 0); cyc();
    ng4 = 0; en4 = 1;              expect_out(4, "pre_r", 4'b0010, 1, 1, 0); cyc();
    en4 = 0;
    for (int i = 0; i < 5; i++) cyc();
    #3 reset = 1;
    #1 expect_out(4, "async_rst", 4'b0001, 0, 0, 0); drain();
    @(posedge clk); #1; reset = 0;
    en4 = 1;                       expect_out(4, "post_rst", 4'b0010, 1, 1, 0); cyc();
    en4 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
